// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the viterbi_tx_rx_2b3 chain: payload handshake, zero tail flush,
// decoder drain window, periodic channel error-injection mask and frame statistics.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned TAIL_LEN   = 2,
    parameter int unsigned DRAIN_LEN  = 64,
    parameter int unsigned ERR_PERIOD = 16,
    parameter int unsigned SYM_W      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             data_valid_i,
    input  logic             data_i,
    output logic             data_ready_o,
    input  logic             err_en_i,
    input  logic [SYM_W-1:0] err_mask_i,
    output logic             encoder_o,
    output logic             enable_encoder_o,
    output logic [SYM_W-1:0] err_inj_o,
    output logic [CNT_W-1:0] word_ct_o,
    output logic [CNT_W-1:0] error_counter_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int unsigned ACC_W      = $clog2(FRAME_LEN + 1);
    localparam int unsigned TL_W       = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam int unsigned DR_W       = (DRAIN_LEN > 0) ? $clog2(DRAIN_LEN + 1) : 1;
    localparam int unsigned PH_W       = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;
    localparam int unsigned POP_W      = $clog2(SYM_W + 1);
    localparam int unsigned SUM_W      = CNT_W + POP_W;
    localparam int unsigned FRAME_LAST = FRAME_LEN - 1;
    localparam int unsigned TAIL_LAST  = (TAIL_LEN > 0) ? TAIL_LEN - 1 : 0;
    localparam int unsigned PH_LAST    = ERR_PERIOD - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TAIL    = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [TL_W-1:0]    tail_q, tail_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               enc_q, enc_d;
    logic               en_q, en_d;
    logic [SYM_W-1:0]   inj_q, inj_d;
    logic [CNT_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]   errc_q, errc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               transfer;
    logic               issue;
    logic               issue_bit;
    logic [POP_W-1:0]   pop;
    logic [SUM_W-1:0]   err_sum;
    logic [CNT_W-1:0]   err_sat;

    assign data_ready_o = (state_q == S_PAYLOAD) && (acc_q < ACC_W'(FRAME_LEN));
    assign transfer     = data_valid_i & data_ready_o;

    // Saturating accumulate of the flipped-bit count of the current mask.
    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(SYM_W); i++) begin
            pop = pop + POP_W'(err_mask_i[i]);
        end
        err_sum = SUM_W'(errc_q) + SUM_W'(pop);
        err_sat = (err_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_W-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        tail_d    = tail_q;
        drain_d   = drain_q;
        phase_d   = phase_q;
        enc_d     = enc_q;
        en_d      = 1'b0;
        inj_d     = '0;
        word_d    = word_q;
        errc_d    = errc_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        issue_bit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_PAYLOAD;
                    acc_d   = '0;
                    word_d  = '0;
                    phase_d = '0;
                    tail_d  = '0;
                    drain_d = '0;
                end
            end
            S_PAYLOAD: begin
                if (transfer) begin
                    issue     = 1'b1;
                    issue_bit = data_i;
                    acc_d     = acc_q + ACC_W'(1);
                    word_d    = word_q + CNT_W'(1);
                    if (acc_q == ACC_W'(FRAME_LAST)) begin
                        state_d = (TAIL_LEN > 0) ? S_TAIL : S_DRAIN;
                        tail_d  = '0;
                        drain_d = '0;
                    end
                end
            end
            S_TAIL: begin
                issue     = 1'b1;
                issue_bit = 1'b0;
                tail_d    = tail_q + TL_W'(1);
                if (tail_q == TL_W'(TAIL_LAST)) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DR_W'(DRAIN_LEN)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every issued symbol (payload or tail) steps the injection phase.
        if (issue) begin
            enc_d   = issue_bit;
            en_d    = 1'b1;
            phase_d = (phase_q == PH_W'(PH_LAST)) ? '0 : phase_q + PH_W'(1);
            if ((phase_q == PH_W'(PH_LAST)) && err_en_i) begin
                inj_d  = err_mask_i;
                errc_d = err_sat;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            tail_q  <= '0;
            drain_q <= '0;
            phase_q <= '0;
            enc_q   <= 1'b0;
            en_q    <= 1'b0;
            inj_q   <= '0;
            word_q  <= '0;
            errc_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tail_q  <= tail_d;
            drain_q <= drain_d;
            phase_q <= phase_d;
            enc_q   <= enc_d;
            en_q    <= en_d;
            inj_q   <= inj_d;
            word_q  <= word_d;
            errc_q  <= errc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign encoder_o        = enc_q;
    assign enable_encoder_o = en_q;
    assign err_inj_o        = inj_q;
    assign word_ct_o        = word_q;
    assign error_counter_o  = errc_q;
    assign busy_o           = busy_q;
    assign frame_done_o     = done_q;

endmodule
